draw_scheduler: RTL

Sequences the card deck for a game: starts the shuffle, deals the opening hands one card at a time in round-robin order, then arbitrates draw requests (1, 2 or 4 cards) from up to N_PLAYERS requesters. Sits between the player/turn logic and the deck block. Translates each accepted request into the deck's one-hot draw command and routes every drawn card to its destination player with a valid strobe.

---
 rtl/draw_scheduler.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/draw_scheduler.sv
// Card-deck sequencer: starts the shuffle, deals opening hands round-robin, then
// arbitrates 1/2/4-card draw requests and routes each drawn card to its player.
module draw_scheduler #(
  parameter int unsigned N_PLAYERS = 4,
  parameter int unsigned HAND_INIT = 7,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_new_game,
  input  logic [N_PLAYERS-1:0]         i_req,
  input  logic [3*N_PLAYERS-1:0]       i_req_cnt,
  output logic [N_PLAYERS-1:0]         o_gnt,
  output logic                         o_deck_start,
  output logic [2:0]                   o_deck_draw,
  input  logic                         i_deck_done,
  input  logic                         i_deck_drawn,
  input  logic [5:0]                   i_deck_card,
  output logic                         o_card_valid,
  output logic [5:0]                   o_card,
  output logic [$clog2(N_PLAYERS)-1:0] o_card_dst,
  output logic                         o_dealt,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int unsigned DST_W     = $clog2(N_PLAYERS);
  localparam int unsigned DEAL_W    = $clog2(N_PLAYERS * HAND_INIT + 1);
  localparam int unsigned WDOG_MIN  = $clog2(TIMEOUT + 1);
  localparam int unsigned WDOG_W    = (WDOG_MIN > 8) ? WDOG_MIN : 8;
  localparam int unsigned DEAL_LAST = N_PLAYERS * HAND_INIT - 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_SHUF    = 3'd2,
    S_ISSUE   = 3'd3,
    S_COLLECT = 3'd4,
    S_SETTLE  = 3'd5,
    S_ARB     = 3'd6
  } state_t;

  state_t              r_state;
  logic                r_dealing;
  logic [DST_W-1:0]    r_dst;
  logic [2:0]          r_remaining;
  logic [DEAL_W-1:0]   r_deal_cnt;
  logic [DST_W-1:0]    r_rr_ptr;
  logic                r_seen_busy;
  logic [WDOG_W-1:0]   r_wdog;
  logic [N_PLAYERS-1:0] r_gnt;
  logic                r_deck_start;
  logic [2:0]          r_deck_draw;
  logic                r_card_valid;
  logic [5:0]          r_card;
  logic [DST_W-1:0]    r_card_dst;
  logic                r_dealt;
  logic                r_busy;
  logic                r_err;

  state_t              w_state_nxt;
  logic                w_dealing_nxt;
  logic [DST_W-1:0]    w_dst_nxt;
  logic [2:0]          w_remaining_nxt;
  logic [DEAL_W-1:0]   w_deal_cnt_nxt;
  logic [DST_W-1:0]    w_rr_ptr_nxt;
  logic                w_seen_busy_nxt;
  logic [WDOG_W-1:0]   w_wdog_nxt;
  logic [N_PLAYERS-1:0] w_gnt_nxt;
  logic                w_deck_start_nxt;
  logic [2:0]          w_deck_draw_nxt;
  logic                w_card_valid_nxt;
  logic [5:0]          w_card_nxt;
  logic [DST_W-1:0]    w_card_dst_nxt;
  logic                w_dealt_nxt;
  logic                w_busy_nxt;
  logic                w_err_nxt;

  logic                w_timed;
  logic                w_arb_found;
  logic [DST_W-1:0]    w_winner;
  logic [DST_W-1:0]    w_idx;
  logic [2:0]          w_field;
  logic [2:0]          w_win_cnt;

  assign w_timed = (r_state == S_SHUF) || (r_state == S_COLLECT) || (r_state == S_SETTLE);

  // Round-robin search starting at rr_ptr; malformed counts fall back to one card
  always_comb begin
    w_arb_found = 1'b0;
    w_winner    = '0;
    w_win_cnt   = 3'd1;
    w_idx       = '0;
    w_field     = 3'd0;
    for (int i = 0; i < int'(N_PLAYERS); i++) begin
      w_idx   = r_rr_ptr + DST_W'(i);
      w_field = i_req_cnt[3*w_idx +: 3];
      if (!w_arb_found && i_req[w_idx]) begin
        w_arb_found = 1'b1;
        w_winner    = w_idx;
        case (w_field)
          3'd1, 3'd2, 3'd4: w_win_cnt = w_field;
          default:          w_win_cnt = 3'd1;
        endcase
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_dealing_nxt    = r_dealing;
    w_dst_nxt        = r_dst;
    w_remaining_nxt  = r_remaining;
    w_deal_cnt_nxt   = r_deal_cnt;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_seen_busy_nxt  = r_seen_busy;
    w_wdog_nxt       = r_wdog;
    w_gnt_nxt        = '0;
    w_deck_start_nxt = 1'b0;
    w_deck_draw_nxt  = 3'b000;
    w_card_valid_nxt = 1'b0;
    w_card_nxt       = r_card;
    w_card_dst_nxt   = r_card_dst;
    w_dealt_nxt      = 1'b0;
    w_busy_nxt       = 1'b0;
    w_err_nxt        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_new_game) w_state_nxt = S_START;
      end
      S_START: begin
        w_seen_busy_nxt = 1'b0;
        w_deal_cnt_nxt  = '0;
        w_dst_nxt       = '0;
        w_dealing_nxt   = 1'b1;
        w_state_nxt     = S_SHUF;
      end
      S_SHUF: begin
        // Only trust i_deck_done after the deck has shown it picked up the shuffle
        if (!i_deck_done) w_seen_busy_nxt = 1'b1;
        if (r_seen_busy && i_deck_done) begin
          w_remaining_nxt = 3'd1;
          w_state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (i_deck_drawn) begin
          w_card_valid_nxt = 1'b1;
          w_card_nxt       = i_deck_card;
          w_card_dst_nxt   = r_dst;
          w_remaining_nxt  = r_remaining - 3'd1;
          if (r_remaining <= 3'd1) w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (i_deck_done) begin
          if (r_dealing) begin
            w_deal_cnt_nxt = r_deal_cnt + DEAL_W'(1);
            w_dst_nxt      = r_dst + DST_W'(1);
            if (r_deal_cnt == DEAL_W'(DEAL_LAST)) begin
              w_dealing_nxt = 1'b0;
              w_dealt_nxt   = 1'b1;
              w_state_nxt   = S_ARB;
            end else begin
              w_remaining_nxt = 3'd1;
              w_state_nxt     = S_ISSUE;
            end
          end else begin
            w_state_nxt = S_ARB;
          end
        end
      end
      S_ARB: begin
        if (i_new_game) begin
          w_state_nxt = S_START;
        end else if (w_arb_found) begin
          w_gnt_nxt       = N_PLAYERS'(1) << w_winner;
          w_dst_nxt       = w_winner;
          w_remaining_nxt = w_win_cnt;
          w_rr_ptr_nxt    = w_winner + DST_W'(1);
          w_state_nxt     = S_ISSUE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Watchdog abort: a waiting state that has lasted TIMEOUT cycles gives up
    if (w_timed && (w_state_nxt == r_state) && (r_wdog == WDOG_W'(TIMEOUT - 1))) begin
      w_state_nxt   = S_IDLE;
      w_err_nxt     = 1'b1;
      w_dealing_nxt = 1'b0;
    end

    if (w_state_nxt != r_state) w_wdog_nxt = '0;
    else if (w_timed)           w_wdog_nxt = r_wdog + WDOG_W'(1);

    // Outputs are registered against the state being entered so they align with it
    w_deck_start_nxt = (w_state_nxt == S_START);
    w_busy_nxt       = (w_state_nxt != S_IDLE) && (w_state_nxt != S_ARB);
    if (w_state_nxt == S_ISSUE)        w_deck_draw_nxt = w_remaining_nxt;
    else if (w_state_nxt == S_COLLECT) w_deck_draw_nxt = r_deck_draw;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_dealing    <= 1'b0;
      r_dst        <= '0;
      r_remaining  <= 3'd0;
      r_deal_cnt   <= '0;
      r_rr_ptr     <= '0;
      r_seen_busy  <= 1'b0;
      r_wdog       <= '0;
      r_gnt        <= '0;
      r_deck_start <= 1'b0;
      r_deck_draw  <= 3'b000;
      r_card_valid <= 1'b0;
      r_card       <= 6'd0;
      r_card_dst   <= '0;
      r_dealt      <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dealing    <= w_dealing_nxt;
      r_dst        <= w_dst_nxt;
      r_remaining  <= w_remaining_nxt;
      r_deal_cnt   <= w_deal_cnt_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_seen_busy  <= w_seen_busy_nxt;
      r_wdog       <= w_wdog_nxt;
      r_gnt        <= w_gnt_nxt;
      r_deck_start <= w_deck_start_nxt;
      r_deck_draw  <= w_deck_draw_nxt;
      r_card_valid <= w_card_valid_nxt;
      r_card       <= w_card_nxt;
      r_card_dst   <= w_card_dst_nxt;
      r_dealt      <= w_dealt_nxt;
      r_busy       <= w_busy_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign o_gnt        = r_gnt;
  assign o_deck_start = r_deck_start;
  assign o_deck_draw  = r_deck_draw;
  assign o_card_valid = r_card_valid;
  assign o_card       = r_card;
  assign o_card_dst   = r_card_dst;
  assign o_dealt      = r_dealt;
  assign o_busy       = r_busy;
  assign o_err        = r_err;

endmodule
